// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch buffer slice.
package if_pkg;

    // Bit positions inside the exception-type vector
    localparam int unsigned IntEcode     = 0;
    localparam int unsigned AdefLocation = 6;
    localparam int unsigned ErtnLocation = 16;

    // Default datapath widths
    localparam int unsigned EXC_W_DEF  = 17;
    localparam int unsigned PC_W_DEF   = 32;
    localparam int unsigned INST_W_DEF = 32;

endpackage

// File: rtl/if_buf_mem.sv
// Circular entry storage: LANES write ports at wr_base+k, LANES read ports at rd_base+k.
module if_buf_mem #(
    parameter int unsigned LANES = 2,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 65
) (
    input  logic                       clk,
    input  logic [LANES-1:0]           wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_base,
    input  logic [LANES*WIDTH-1:0]     wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_base,
    output logic [LANES*WIDTH-1:0]     rd_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write accepted lanes at consecutive slots; pointer arithmetic wraps at DEPTH
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (wr_en[k]) begin
                mem[wr_base + PTR_W'(k)] <= wr_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Head-relative combinational read ports
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < LANES; k++) begin
            rd_data[k*WIDTH +: WIDTH] = mem[rd_base + PTR_W'(k)];
        end
    end

endmodule

// File: rtl/if_fetch_buffer.sv
// Fetch-to-decode instruction buffer: multi-lane enqueue, in-order multi-lane issue
// with address-error and interrupt tagging, flush and synchronous reset.
module if_fetch_buffer
    import if_pkg::*;
#(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PC_W   = PC_W_DEF,
    parameter int unsigned INST_W = INST_W_DEF,
    parameter int unsigned EXC_W  = EXC_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    input  logic                        interrupt_en_i,
    input  logic                        in_valid_i,
    input  logic [LANES-1:0]            in_lane_en_i,
    input  logic [LANES*PC_W-1:0]       in_pc_i,
    input  logic [LANES*INST_W-1:0]     in_inst_i,
    output logic                        in_ready_o,
    input  logic                        out_ready_i,
    output logic [LANES-1:0]            out_valid_o,
    output logic [LANES*PC_W-1:0]       out_pc_o,
    output logic [LANES*INST_W-1:0]     out_inst_o,
    output logic [LANES-1:0]            out_excep_en_o,
    output logic [LANES*EXC_W-1:0]      out_excep_type_o,
    output logic [$clog2(DEPTH+1)-1:0]  count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned LN_W  = $clog2(LANES + 1);
    localparam int unsigned ENT_W = PC_W + INST_W + 1;

    logic [PTR_W-1:0]       head_q;
    logic [PTR_W-1:0]       tail_q;
    logic [CNT_W-1:0]       count_q;
    logic                   in_ready_q;

    logic [LN_W-1:0]        enq_n;
    logic [LN_W-1:0]        enq_acc;
    logic [LN_W-1:0]        deq_n;
    logic                   do_enq;
    logic                   run;
    logic                   blocked;
    logic                   entry_adef;
    logic [CNT_W-1:0]       count_next;
    logic [LANES-1:0]       wr_en;
    logic [LANES*ENT_W-1:0] wr_data;
    logic [LANES*ENT_W-1:0] rd_data;

    // Accepted lanes: leading run of enabled lanes starting at lane 0
    always_comb begin
        enq_n = '0;
        run   = 1'b1;
        for (int k = 0; k < LANES; k++) begin
            if (run && in_lane_en_i[k]) begin
                enq_n = enq_n + LN_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    // Enqueue qualification and entry packing {adef, pc, inst}
    always_comb begin
        do_enq  = in_valid_i && in_ready_q && !flush_i;
        enq_acc = do_enq ? enq_n : '0;
        wr_en   = '0;
        wr_data = '0;
        for (int k = 0; k < LANES; k++) begin
            wr_en[k] = do_enq && (LN_W'(k) < enq_n);
            wr_data[k*ENT_W +: ENT_W] = {(in_pc_i[k*PC_W +: 2] != 2'b00),
                                         in_pc_i[k*PC_W +: PC_W],
                                         in_inst_i[k*INST_W +: INST_W]};
        end
    end

    if_buf_mem #(
        .LANES (LANES),
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_base (tail_q),
        .wr_data (wr_data),
        .rd_base (head_q),
        .rd_data (rd_data)
    );

    // Issue group: in order from head, nothing issues past an excepting instruction
    always_comb begin
        out_valid_o      = '0;
        out_excep_en_o   = '0;
        out_excep_type_o = '0;
        out_pc_o         = '0;
        out_inst_o       = '0;
        blocked          = 1'b0;
        entry_adef       = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            entry_adef = rd_data[k*ENT_W + ENT_W - 1];
            out_pc_o[k*PC_W +: PC_W]       = rd_data[k*ENT_W + INST_W +: PC_W];
            out_inst_o[k*INST_W +: INST_W] = rd_data[k*ENT_W +: INST_W];
            out_valid_o[k] = (count_q > CNT_W'(k)) && !blocked;
            if (k == 0) begin
                out_excep_en_o[k] = out_valid_o[k] && (interrupt_en_i || entry_adef);
                out_excep_type_o[k*EXC_W + IntEcode] = out_valid_o[k] && interrupt_en_i;
                blocked = out_excep_en_o[k];
            end else begin
                out_excep_en_o[k] = out_valid_o[k] && entry_adef;
            end
            out_excep_type_o[k*EXC_W + AdefLocation] = out_valid_o[k] && entry_adef;
            blocked = blocked || entry_adef;
        end
    end

    // Dequeue count: every issued lane retires when decode accepts
    always_comb begin
        deq_n = '0;
        if (out_ready_i) begin
            for (int k = 0; k < LANES; k++) begin
                deq_n = deq_n + LN_W'(out_valid_o[k]);
            end
        end
        count_next = count_q + CNT_W'(enq_acc) - CNT_W'(deq_n);
    end

    // Pointer, occupancy and ready registers
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
        end else if (flush_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            head_q     <= head_q + PTR_W'(deq_n);
            tail_q     <= tail_q + PTR_W'(enq_acc);
            count_q    <= count_next;
            in_ready_q <= (CNT_W'(DEPTH) - count_next) >= CNT_W'(LANES);
        end
    end

    assign in_ready_o = in_ready_q;
    assign count_o    = count_q;

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Self-checking bench for if_fetch_buffer (LANES=2, DEPTH=8) against a queue model.
module tb_if_fetch_buffer;
    import if_pkg::*;

    localparam int unsigned LANES = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned EXC_W = 17;

    logic                clk = 1'b0;
    logic                rst;
    logic                flush_i;
    logic                interrupt_en_i;
    logic                in_valid_i;
    logic [1:0]          in_lane_en_i;
    logic [63:0]         in_pc_i;
    logic [63:0]         in_inst_i;
    logic                in_ready_o;
    logic                out_ready_i;
    logic [1:0]          out_valid_o;
    logic [63:0]         out_pc_o;
    logic [63:0]         out_inst_o;
    logic [1:0]          out_excep_en_o;
    logic [2*EXC_W-1:0]  out_excep_type_o;
    logic [3:0]          count_o;

    if_fetch_buffer #(
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush_i),
        .interrupt_en_i   (interrupt_en_i),
        .in_valid_i       (in_valid_i),
        .in_lane_en_i     (in_lane_en_i),
        .in_pc_i          (in_pc_i),
        .in_inst_i        (in_inst_i),
        .in_ready_o       (in_ready_o),
        .out_ready_i      (out_ready_i),
        .out_valid_o      (out_valid_o),
        .out_pc_o         (out_pc_o),
        .out_inst_o       (out_inst_o),
        .out_excep_en_o   (out_excep_en_o),
        .out_excep_type_o (out_excep_type_o),
        .count_o          (count_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;
    ent_t q[$];

    logic [1:0]         exp_valid;
    logic [1:0]         exp_een;
    logic [2*EXC_W-1:0] exp_type;
    logic [63:0]        exp_pc;
    logic [63:0]        exp_inst;
    int                 exp_count;
    bit                 exp_ready;

    // Expected outputs: issue in program order, stopping after the first excepting instruction
    function automatic void compute_exp();
        bit stop = 1'b0;
        bit adef;
        bit exc;
        exp_count = q.size();
        exp_ready = (int'(DEPTH) - q.size()) >= int'(LANES);
        exp_valid = '0;
        exp_een   = '0;
        exp_type  = '0;
        exp_pc    = '0;
        exp_inst  = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            if (k < q.size() && !stop) begin
                adef = (q[k].pc[1:0] != 2'b00);
                exc  = adef || (k == 0 && interrupt_en_i);
                exp_valid[k] = 1'b1;
                exp_pc[k*32 +: 32]   = q[k].pc;
                exp_inst[k*32 +: 32] = q[k].inst;
                exp_een[k] = exc;
                if (k == 0 && interrupt_en_i) exp_type[k*EXC_W + IntEcode] = 1'b1;
                if (adef) exp_type[k*EXC_W + AdefLocation] = 1'b1;
                stop = exc;
            end
        end
    endfunction

    task automatic drive(input bit r, input bit f, input bit intr, input bit v,
                         input logic [1:0] en, input logic [31:0] pc0, input logic [31:0] pc1,
                         input bit ordy);
        rst            = r;
        flush_i        = f;
        interrupt_en_i = intr;
        in_valid_i     = v;
        in_lane_en_i   = en;
        in_pc_i        = {pc1, pc0};
        in_inst_i      = {~pc1 ^ 32'h5A5A_0000, ~pc0 ^ 32'h5A5A_0000};
        out_ready_i    = ordy;
        #1;
    endtask

    // Advance one clock and apply the same cycle to the model
    task automatic tick();
        int ndeq;
        bit acc;
        bit run;
        ent_t e;
        compute_exp();
        ndeq = out_ready_i ? $countones(exp_valid) : 0;
        acc  = in_valid_i && exp_ready && !flush_i;
        @(posedge clk);
        if (rst || flush_i) begin
            q.delete();
        end else begin
            for (int i = 0; i < ndeq; i++) void'(q.pop_front());
            run = acc;
            for (int k = 0; k < int'(LANES); k++) begin
                if (run && in_lane_en_i[k]) begin
                    e.pc   = in_pc_i[k*32 +: 32];
                    e.inst = in_inst_i[k*32 +: 32];
                    q.push_back(e);
                end else begin
                    run = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input bit ordy, input bit intr);
        drive(1'b0, 1'b0, intr, 1'b0, 2'b00, 32'h0, 32'h0, ordy);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        idle(1'b0, 1'b0);
        tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", in_ready_o); end
        tests++; if (out_valid_o !== 2'b00) begin fails++; $display("FAIL reset_valid: got %b expected 00", out_valid_o); end
        tests++; if (out_excep_en_o !== 2'b00) begin fails++; $display("FAIL reset_excep: got %b expected 00", out_excep_en_o); end
    endtask

    task automatic test_basic();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 32'h1C00_0000, 32'h1C00_0004, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
        tests++; if (out_valid_o !== 2'b11) begin fails++; $display("FAIL basic_valid: got %b expected 11", out_valid_o); end
        tests++; if (count_o !== 4'd2) begin fails++; $display("FAIL basic_count2: got %0d expected 2", count_o); end
        tests++; if (out_pc_o !== {32'h1C00_0004, 32'h1C00_0000}) begin fails++; $display("FAIL basic_pc: got %h expected 1c0000041c000000", out_pc_o); end
        tests++; if (out_inst_o[31:0] !== (~32'h1C00_0000 ^ 32'h5A5A_0000)) begin fails++; $display("FAIL basic_inst: got %h", out_inst_o[31:0]); end
        tick();
        idle(1'b0, 1'b0);
        tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL basic_count0: got %0d expected 0", count_o); end
        tests++; if (out_valid_o !== 2'b00) begin fails++; $display("FAIL basic_empty_valid: got %b expected 00", out_valid_o); end
    endtask

    task automatic test_lane_en();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 32'h1C00_0040, 32'h1C00_0044, 1'b0);
        tick();
        idle(1'b0, 1'b0);
        tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL lane_en10_count: got %0d expected 0", count_o); end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 32'h1C00_0048, 32'h1C00_004C, 1'b0);
        tick();
        idle(1'b0, 1'b0);
        tests++; if (count_o !== 4'd1) begin fails++; $display("FAIL lane_en01_count: got %0d expected 1", count_o); end
        tests++; if (out_valid_o !== 2'b01) begin fails++; $display("FAIL lane_en01_valid: got %b expected 01", out_valid_o); end
        idle(1'b1, 1'b0);
        tick();
    endtask

    task automatic test_adef();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 32'h1C00_0002, 32'h1C00_0004, 1'b0);
        tick();
        idle(1'b0, 1'b0);
        tests++; if (out_valid_o !== 2'b01) begin fails++; $display("FAIL adef_valid: got %b expected 01", out_valid_o); end
        tests++; if (out_excep_en_o !== 2'b01) begin fails++; $display("FAIL adef_excep: got %b expected 01", out_excep_en_o); end
        tests++; if (out_excep_type_o !== {17'h0, 17'h00040}) begin fails++; $display("FAIL adef_type: got %h expected 00040", out_excep_type_o); end
        idle(1'b1, 1'b0);
        tick();
        idle(1'b0, 1'b0);
        tests++; if (out_valid_o !== 2'b01) begin fails++; $display("FAIL adef_next_valid: got %b expected 01", out_valid_o); end
        tests++; if (out_pc_o[31:0] !== 32'h1C00_0004) begin fails++; $display("FAIL adef_next_pc: got %h expected 1c000004", out_pc_o[31:0]); end
        tests++; if (out_excep_en_o !== 2'b00) begin fails++; $display("FAIL adef_next_excep: got %b expected 00", out_excep_en_o); end
        idle(1'b1, 1'b0);
        tick();
    endtask

    task automatic test_interrupt();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 32'h1C00_0010, 32'h1C00_0014, 1'b0);
        tick();
        idle(1'b0, 1'b1);
        tests++; if (out_valid_o !== 2'b01) begin fails++; $display("FAIL int_valid: got %b expected 01", out_valid_o); end
        tests++; if (out_excep_en_o !== 2'b01) begin fails++; $display("FAIL int_excep: got %b expected 01", out_excep_en_o); end
        tests++; if (out_excep_type_o !== {17'h0, 17'h00001}) begin fails++; $display("FAIL int_type: got %h expected 00001", out_excep_type_o); end
        idle(1'b1, 1'b1);
        tick();
        idle(1'b0, 1'b0);
        tests++; if (count_o !== 4'd1) begin fails++; $display("FAIL int_count: got %0d expected 1", count_o); end
        idle(1'b1, 1'b0);
        tick();
    endtask

    task automatic test_full_wrap();
        logic [31:0] pc = 32'h1C00_0100;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, pc, pc + 32'd4, 1'b0);
            tick();
            pc = pc + 32'd8;
        end
        idle(1'b0, 1'b0);
        tests++; if (count_o !== 4'd6 || in_ready_o !== 1'b1) begin fails++; $display("FAIL full_6: got count %0d ready %b expected 6/1", count_o, in_ready_o); end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, pc, pc + 32'd4, 1'b0);
        tick();
        pc = pc + 32'd4;
        idle(1'b0, 1'b0);
        tests++; if (count_o !== 4'd7 || in_ready_o !== 1'b0) begin fails++; $display("FAIL full_7: got count %0d ready %b expected 7/0", count_o, in_ready_o); end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 32'h0BAD_0000, 32'h0BAD_0004, 1'b0);
        tick();
        idle(1'b0, 1'b0);
        tests++; if (count_o !== 4'd7) begin fails++; $display("FAIL full_hold: got count %0d expected 7", count_o); end
        idle(1'b1, 1'b0);
        tick();
        idle(1'b0, 1'b0);
        tests++; if (count_o !== 4'd5 || in_ready_o !== 1'b1) begin fails++; $display("FAIL full_deq: got count %0d ready %b expected 5/1", count_o, in_ready_o); end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, pc, 32'h0, 1'b0);
        tick();
        pc = pc + 32'd4;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, pc, pc + 32'd4, 1'b0);
        tick();
        idle(1'b0, 1'b0);
        tests++; if (count_o !== 4'd8 || in_ready_o !== 1'b0) begin fails++; $display("FAIL full_8: got count %0d ready %b expected 8/0", count_o, in_ready_o); end
        pc = 32'h1C00_0108;
        for (int i = 0; i < 4; i++) begin
            idle(1'b1, 1'b0);
            tests++; if (out_pc_o !== {pc + 32'd4, pc}) begin fails++; $display("FAIL wrap_order_%0d: got %h expected %h", i, out_pc_o, {pc + 32'd4, pc}); end
            tick();
            pc = pc + 32'd8;
        end
        idle(1'b0, 1'b0);
        tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL wrap_drain: got %0d expected 0", count_o); end
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 32'h1C00_0200 + 32'(i*8), 32'h1C00_0204 + 32'(i*8), 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 32'h1C00_0210, 32'h0, 1'b0);
        tick();
        idle(1'b0, 1'b0);
        tests++; if (count_o !== 4'd5) begin fails++; $display("FAIL flush_pre: got %0d expected 5", count_o); end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 32'h1C00_0300, 32'h1C00_0304, 1'b1);
        tick();
        idle(1'b0, 1'b0);
        tests++; if (count_o !== 4'd0 || out_valid_o !== 2'b00 || in_ready_o !== 1'b1) begin fails++; $display("FAIL flush: got count %0d valid %b ready %b expected 0/00/1", count_o, out_valid_o, in_ready_o); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 32'h1C00_0400 + 32'(i*8), 32'h1C00_0404 + 32'(i*8), 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 32'h1C00_0500, 32'h1C00_0504, 1'b1);
        tick();
        idle(1'b0, 1'b0);
        tests++; if (count_o !== 4'd0 || out_valid_o !== 2'b00 || in_ready_o !== 1'b1) begin fails++; $display("FAIL reset_mid: got count %0d valid %b ready %b expected 0/00/1", count_o, out_valid_o, in_ready_o); end
    endtask

    task automatic test_random();
        logic [31:0] pc0;
        logic [31:0] pc1;
        for (int c = 0; c < 600; c++) begin
            pc0 = $urandom() & 32'hFFFF_FFFC;
            pc1 = pc0 + 32'd4;
            if ($urandom_range(0, 7) == 0) pc0[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) pc1[1:0] = 2'($urandom_range(1, 3));
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7,
                  2'($urandom_range(0, 3)), pc0, pc1, $urandom_range(0, 9) < 6);
            compute_exp();
            tests++; if (count_o !== 4'(exp_count)) begin fails++; $display("FAIL rnd_count c%0d: got %0d expected %0d", c, count_o, exp_count); end
            tests++; if (in_ready_o !== exp_ready) begin fails++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, in_ready_o, exp_ready); end
            tests++; if (out_valid_o !== exp_valid) begin fails++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, out_valid_o, exp_valid); end
            tests++; if (out_excep_en_o !== exp_een) begin fails++; $display("FAIL rnd_excep c%0d: got %b expected %b", c, out_excep_en_o, exp_een); end
            tests++; if (out_excep_type_o !== exp_type) begin fails++; $display("FAIL rnd_type c%0d: got %h expected %h", c, out_excep_type_o, exp_type); end
            for (int k = 0; k < int'(LANES); k++) begin
                if (exp_valid[k]) begin
                    tests++;
                    if (out_pc_o[k*32 +: 32] !== exp_pc[k*32 +: 32] || out_inst_o[k*32 +: 32] !== exp_inst[k*32 +: 32]) begin
                        fails++;
                        $display("FAIL rnd_data c%0d lane%0d: got %h/%h expected %h/%h", c, k,
                                 out_pc_o[k*32 +: 32], out_inst_o[k*32 +: 32], exp_pc[k*32 +: 32], exp_inst[k*32 +: 32]);
                    end
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lane_en();
        test_adef();
        test_interrupt();
        test_full_wrap();
        test_flush_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
